// File: rtl/sram_pkg.sv
// Shared constants for the MEM-stage SRAM sequencer: FSM encoding, default
// memory-map parameters and half-word select values.
`timescale 1ns/1ps
package sram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StLo   = 3'd1;
    localparam state_t StHi   = 3'd2;
    localparam state_t StWait = 3'd3;
    localparam state_t StDone = 3'd4;

    localparam logic [31:0] BaseAddrDefault   = 32'd1024;
    localparam int unsigned WaitCyclesDefault = 3;
    localparam int unsigned SramAwDefault     = 18;

    localparam logic HwLo = 1'b0;
    localparam logic HwHi = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses plus a settle
// period, holding `ready` low so the pipeline freezes until the access is done.
`timescale 1ns/1ps
module sram_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BaseAddrDefault,
    parameter int unsigned WAIT_CYCLES = WaitCyclesDefault,
    parameter int unsigned SRAM_AW     = SramAwDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;

    logic               req;
    logic [31:0]        offset;
    logic [SRAM_AW-1:0] lo_addr;
    logic [SRAM_AW-1:0] hi_addr;
    logic               drive;
    logic               hw_sel;
    logic               unused_offset;

    assign req     = rd_en | wr_en;
    // Wraps mod 2^32; addresses below BASE_ADDR alias high in the SRAM.
    assign offset  = address - BASE_ADDR;
    assign lo_addr = {offset[SRAM_AW:2], 1'b0};
    assign hi_addr = {addr_q[SRAM_AW-1:1], 1'b1};
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        ready   = 1'b0;
        drive   = 1'b0;
        hw_sel  = HwLo;

        case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) begin
                    op_wr_d = wr_en;
                    wdata_d = write_data;
                    addr_d  = lo_addr;
                    state_d = StLo;
                end
            end
            StLo: begin
                drive = op_wr_q;
                if (!op_wr_q) begin
                    rbuf_d[15:0] = sram_dq_in;
                end
                addr_d  = hi_addr;
                state_d = StHi;
            end
            StHi: begin
                hw_sel = HwHi;
                drive  = op_wr_q;
                if (!op_wr_q) begin
                    rbuf_d[31:16] = sram_dq_in;
                end
                if (WAIT_CYCLES == 0) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = WaitLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Request is still high here: it is the same frozen instruction.
                ready = 1'b1;
                if (!op_wr_q) begin
                    rdata_d = rbuf_q;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_oe  = drive;
    assign sram_we_n   = ~drive;
    assign sram_dq_out = !drive ? 16'd0 : (hw_sel == HwHi) ? wdata_q[31:16] : wdata_q[15:0];

endmodule
